shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-bit shift sequencer for the 16-bit signed ALU shift unit.
- Accepts a shift request (operand, amount, direction) over a valid/ready handshake.
- Drives the single-bit registered shift unit once per bit, feeding each result back as the next operand.
- Returns the final value over a valid/ready response handshake. Sits between the ALU command decoder and the shift unit.

Parameters:
- WIDTH, 16, operand/result width; matches the shift unit WIDTH.
- AMT_W, 4, shift-amount width; legal amounts 0..2^AMT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_data  in  WIDTH  signed operand.
- req_amt  in  AMT_W  number of 1-bit shifts.
- req_dir  in  1  0 = right (shift-unit function 00, logical), 1 = left (function 01).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result when resp_valid & resp_ready.
- resp_data  out  WIDTH  shifted result.
- busy  out  1  high in every state except IDLE.
- su_A  out  WIDTH  operand to shift unit A.
- su_B  out  WIDTH  operand to shift unit B; constant 0.
- su_enable  out  1  shift unit Shift_enable.
- su_fun  out  2  shift unit ALU_FUN = {1'b0, dir}.
- su_out  in  WIDTH  low WIDTH bits of shift unit Shift_out.
- su_flag  in  1  shift unit Shift_Flag; marks su_out valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset: state IDLE; req_ready, resp_valid, busy, su_enable = 0; resp_data, su_A = 0; su_fun = 00; internal work/count/dir registers = 0.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - req_ready = 1.
  - On accept: work <= req_data, count <= req_amt, dir <= req_dir.
  - Next state is DONE if req_amt == 0 (resp_data <= req_data); otherwise ISSUE.
- ISSUE:
  - su_enable = 1, su_A = work, su_fun = {0, dir}; lasts one cycle.
  - Next state: WAIT.
- WAIT:
  - su_enable = 0. The shift unit presents its result one cycle after enable.
  - If su_flag == 1: work <= su_out, count <= count - 1.
    - If count == 1: resp_data <= su_out, next state DONE.
    - Otherwise: next state ISSUE.
  - If su_flag == 0: hold in WAIT with work and count unchanged (stall, no timeout).
- DONE:
  - resp_valid = 1; resp_data held stable.
  - Leave to IDLE on resp_valid & resp_ready.
  - resp_valid stays high until the handshake.
  - req_ready = 0, so a new request cannot be accepted in the same cycle.
- Latency with no stalls: resp_valid first asserts 2*N+1 cycles after the accept cycle (N = req_amt). Examples: N = 0 → 1 cycle; N = 15 → 31 cycles.
- Throughput: one request in flight. The next accept happens at the earliest one cycle after the response handshake, because IDLE is re-entered first.
- Shift semantics, per step:
  - Right: logical; zero fill in MSB, no sign extension.
  - Left: zero fill in LSB; bits shifted past the MSB are lost.
  - No overflow flag.
- Reset mid-operation (any state): abort immediately; no response is produced; outputs return to reset values on the next edge.
- Request fields are sampled only at accept; input changes while busy are ignored.
- req_valid is ignored outside IDLE.

Test Plan:
- Reset → all outputs 0 and req_ready = 1 in the cycle after rst deasserts. Assert rst mid-WAIT → busy = 0 and resp_valid never asserts for the aborted request.
- req_data = 0x1234, amt = 4, dir = 1, resp_ready = 1 → resp_data = 0x2340, resp_valid exactly 9 cycles after accept; su_enable pulses 4 times, each 2 cycles apart.
- req_data = 0x8000, amt = 15, dir = 0 → resp_data = 0x0001 at cycle 31 (logical fill); amt = 1 gives 0x4000 at cycle 3.
- amt = 0, req_data = 0xBEEF → resp_data = 0xBEEF at cycle 1; su_enable never asserts.
- resp_ready held low 5 cycles in DONE → resp_valid and resp_data stable and req_ready = 0; accept occurs on resp_ready, and a back-to-back request is accepted in the following IDLE cycle.
- Force su_flag = 0 for 3 cycles in WAIT → FSM stays in WAIT and result latency grows by exactly 3 cycles; result value is unchanged.

Source files
------------

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and shift-unit signal bundle for the multi-bit shift sequencer.
// slave = sequencer view; master = command decoder plus shift unit view.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_dir;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             busy;

    logic [WIDTH-1:0] su_A;
    logic [WIDTH-1:0] su_B;
    logic             su_enable;
    logic [1:0]       su_fun;
    logic [WIDTH-1:0] su_out;
    logic             su_flag;

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, resp_ready, su_out, su_flag,
        output req_ready, resp_valid, resp_data, busy, su_A, su_B, su_enable, su_fun
    );

    modport master (
        output req_valid, req_data, req_amt, req_dir, resp_ready, su_out, su_flag,
        input  req_ready, resp_valid, resp_data, busy, su_A, su_B, su_enable, su_fun
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequences an N-bit shift as N single-bit passes through the registered shift unit.
// Latency 2*N+1 cycles from accept to resp_valid, plus any su_flag stall cycles.
// One request in flight; req_ready low while busy, resp_valid held until resp_ready.
module shift_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [AMT_W-1:0] count, count_nxt;
    logic             dir, dir_nxt;
    logic [WIDTH-1:0] resp_data_q, resp_data_nxt;

    logic             req_ready_q;
    logic             resp_valid_q;
    logic             busy_q;
    logic             su_enable_q;
    logic [WIDTH-1:0] su_a_q;
    logic [1:0]       su_fun_q;

    // req_ready_q is only ever high in IDLE, so this is the real accept.
    logic accept;
    assign accept = bus.req_valid & req_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            work  <= '0;
            count <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        count_nxt     = count;
        dir_nxt       = dir;
        resp_data_nxt = resp_data_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    work_nxt  = bus.req_data;
                    count_nxt = bus.req_amt;
                    dir_nxt   = bus.req_dir;
                    if (bus.req_amt == '0) begin
                        resp_data_nxt = bus.req_data;
                        state_nxt     = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // A missing su_flag simply holds here; the shift unit owns the stall.
                if (bus.su_flag) begin
                    work_nxt  = bus.su_out;
                    count_nxt = count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        resp_data_nxt = bus.su_out;
                        state_nxt     = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (resp_valid_q && bus.resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered off the next state so nothing from an input reaches a port.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            su_enable_q  <= 1'b0;
            su_a_q       <= '0;
            su_fun_q     <= 2'b00;
            resp_data_q  <= '0;
        end else begin
            req_ready_q  <= (state_nxt == S_IDLE);
            resp_valid_q <= (state_nxt == S_DONE);
            busy_q       <= (state_nxt != S_IDLE);
            su_enable_q  <= (state_nxt == S_ISSUE);
            resp_data_q  <= resp_data_nxt;
            if (state_nxt == S_ISSUE) begin
                su_a_q   <= work_nxt;
                su_fun_q <= {1'b0, dir_nxt};
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_q;
    assign bus.su_enable  = su_enable_q;
    assign bus.su_A       = su_a_q;
    assign bus.su_B       = '0;
    assign bus.su_fun     = su_fun_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: vector table, hand-written corner sequences and random requests
// against a whole-shift reference, with a behavioural single-bit shift unit attached.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(16), .AMT_W(4)) bus ();

    shift_seq_ctrl #(.WIDTH(16), .AMT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Single-bit shift unit: result and flag one cycle after enable; one chosen
    // enable (by index) has its flag held off for three extra cycles.
    int   en_cnt    = 0;
    int   stall_idx = -1;
    int   dly       = 0;
    logic pend      = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            bus.su_flag <= 1'b0;
            pend        <= 1'b0;
            dly         <= 0;
        end else if (bus.su_enable) begin
            bus.su_out <= bus.su_fun[0] ? (bus.su_A << 1) : (bus.su_A >> 1);
            en_cnt     <= en_cnt + 1;
            if (en_cnt == stall_idx) begin
                pend        <= 1'b1;
                dly         <= 3;
                bus.su_flag <= 1'b0;
            end else begin
                bus.su_flag <= 1'b1;
            end
        end else if (pend) begin
            if (dly == 1) begin
                bus.su_flag <= 1'b1;
                pend        <= 1'b0;
            end else begin
                bus.su_flag <= 1'b0;
            end
            dly <= dly - 1;
        end else begin
            bus.su_flag <= 1'b0;
        end
    end

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int a, input logic dr);
        logic [31:0] w;
        w = {16'h0000, d};
        return dr ? w[15:0] << a : w[15:0] >> a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request, measures accept-to-resp_valid cycles and enable pulses,
    // holds resp_ready low for 'hold' cycles, then completes the handshake.
    task automatic run_txn(input logic [15:0] d, input logic [3:0] a, input logic dr,
                           input int hold, output logic [15:0] rd, output int lat, output int ens);
        int cyc;
        int en0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_data   = d;
        bus.req_amt    = a;
        bus.req_dir    = dr;
        bus.resp_ready = 1'b0;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.req_ready) check("accept_timeout", 32'd1, 32'd0);
        en0 = en_cnt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_data  = 16'($urandom);
        bus.req_amt   = 4'($urandom);
        bus.req_dir   = 1'($urandom);
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (hold) @(negedge clk);
        rd = bus.resp_data;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        ens = en_cnt - en0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  amt;
        logic        dir;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd, rd0;
        int lat, ens, bad, seen;

        vecs[0] = '{16'h1234, 4'd4,  1'b1, 16'h2340, 9};
        vecs[1] = '{16'h8000, 4'd15, 1'b0, 16'h0001, 31};
        vecs[2] = '{16'h8000, 4'd1,  1'b0, 16'h4000, 3};
        vecs[3] = '{16'hBEEF, 4'd0,  1'b1, 16'hBEEF, 1};
        vecs[4] = '{16'hFFFF, 4'd15, 1'b1, 16'h8000, 31};
        vecs[5] = '{16'hF0F0, 4'd7,  1'b0, 16'h01E1, 15};

        bus.req_valid  = 1'b0;
        bus.req_data   = '0;
        bus.req_amt    = '0;
        bus.req_dir    = 1'b0;
        bus.resp_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_outs", {bus.resp_valid, bus.su_enable, bus.su_fun, bus.busy},  32'd0);
        check("post_rst_data", {bus.resp_data, bus.su_A}, 32'd0);
        check("su_B_zero", 32'(bus.su_B), 32'd0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].data, vecs[i].amt, vecs[i].dir, 0, rd, lat, ens);
            check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_enables", i), 32'(ens), 32'(vecs[i].amt));
        end

        // DONE held with resp_ready low while a second request waits
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = 16'h00F0;
        bus.req_amt   = 4'd2;
        bus.req_dir   = 1'b0;
        seen = 0;
        while (!bus.req_ready && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        bus.req_data = 16'h0F00;
        bus.req_amt  = 4'd3;
        bus.req_dir  = 1'b1;
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lat", 32'(lat), 32'd5);
        rd0 = bus.resp_data;
        check("hold_data", 32'(rd0), 32'h003C);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_data !== rd0 || bus.req_ready) bad++;
        end
        check("hold_bad_cycles", 32'(bad), 32'd0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("b2b_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", 32'(lat), 32'd7);
        check("b2b_data", 32'(bus.resp_data), 32'h7800);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;

        // Shift unit holds su_flag off for three cycles on the second step
        stall_idx = en_cnt + 1;
        run_txn(16'h1234, 4'd4, 1'b1, 0, rd, lat, ens);
        stall_idx = -1;
        check("stall_data", 32'(rd), 32'h2340);
        check("stall_lat", 32'(lat), 32'd12);
        check("stall_enables", 32'(ens), 32'd4);

        // Reset while waiting for the shift unit
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = 16'hAAAA;
        bus.req_amt   = 4'd5;
        bus.req_dir   = 1'b1;
        stall_idx     = en_cnt;
        seen = 0;
        while (!bus.req_ready && seen < 50) begin
            @(negedge clk);
            seen++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_issue_en", 32'(bus.su_enable), 32'd1);
        @(negedge clk);
        check("abort_wait", {bus.busy, bus.su_enable}, 32'b10);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {bus.busy, bus.resp_valid}, 32'd0);
        rst       = 1'b0;
        stall_idx = -1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        check("abort_no_resp", 32'(seen), 32'd0);
        run_txn(16'h0001, 4'd3, 1'b1, 0, rd, lat, ens);
        check("recover_data", 32'(rd), 32'h0008);

        // Random requests against the whole-shift reference
        for (int t = 0; t < 40; t++) begin
            logic [15:0] d;
            logic [3:0]  a;
            logic        dr;
            d  = 16'($urandom);
            a  = 4'($urandom_range(0, 15));
            dr = 1'($urandom);
            run_txn(d, a, dr, int'($urandom_range(0, 3)), rd, lat, ens);
            check($sformatf("rand%0d_data", t), 32'(rd), 32'(ref_shift(d, int'(a), dr)));
            check($sformatf("rand%0d_lat", t), 32'(lat), 32'(2 * int'(a) + 1));
            check($sformatf("rand%0d_enables", t), 32'(ens), 32'(a));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
